// File: rtl/cnt_cmd_pkg.sv
// Shared types for the counter command sequencer.
//   op_e    : command opcodes carried on cmd_op
//   state_e : sequencer FSM states
package cnt_cmd_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_UP   = 2'b01,
      OP_DOWN = 2'b10,
      OP_READ = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_RUN  = 2'b10,
      S_RESP = 2'b11
   } state_e;

endpackage

// File: rtl/cnt_cmd_ctrl.sv
// Command sequencer for an up/down counter.
// Accepts LOAD/UP/DOWN/READ commands on a valid/ready handshake, drives the
// counter's load_en/load/down inputs cycle by cycle, and returns the final
// count plus a wrap flag on a response handshake.
//
// Ports:
//   clk, rstn                        clock, async active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_op, cmd_value, cmd_steps     command fields
//   count_i, rollover_i              counter readback
//   load_en, load, down              counter control
//   busy                             high outside IDLE
//   rsp_valid/rsp_ready              response handshake
//   rsp_count, rsp_wrap              response payload (0 when rsp_valid=0)
//
// state  | meaning
// -------+---------------------------------------------------------
// S_IDLE | waiting for a command, counter frozen by reloading itself
// S_LOAD | one cycle loading value_q into the counter
// S_RUN  | counter free-running up/down for `remaining` edges
// S_RESP | response offered, counter frozen until rsp_ready
module cnt_cmd_ctrl
   import cnt_cmd_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [WIDTH-1:0]  cmd_value,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic [WIDTH-1:0]  count_i,
   input  logic              rollover_i,
   output logic              load_en,
   output logic [WIDTH-1:0]  load,
   output logic              down,
   output logic              busy,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WIDTH-1:0]  rsp_count,
   output logic              rsp_wrap
);

   state_e              state;
   op_e                 op_q;
   logic [WIDTH-1:0]    value_q;
   logic [STEP_W-1:0]   remaining;
   logic                wrap_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         op_q      <= OP_LOAD;
         value_q   <= '0;
         remaining <= '0;
         wrap_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q      <= op_e'(cmd_op);
                  value_q   <= cmd_value;
                  remaining <= cmd_steps;
                  wrap_q    <= 1'b0;
                  case (op_e'(cmd_op))
                     OP_LOAD:         state <= S_LOAD;
                     OP_UP, OP_DOWN:  state <= (cmd_steps != '0) ? S_RUN : S_RESP;
                     default:         state <= S_RESP;
                  endcase
               end
            end
            S_LOAD: state <= S_RESP;
            S_RUN: begin
               remaining <= remaining - STEP_W'(1);
               // The edge closing this cycle wraps when counting up from
               // all-ones or down from zero.
               if ((op_q == OP_UP && rollover_i) ||
                   (op_q == OP_DOWN && count_i == '0))
                  wrap_q <= 1'b1;
               if (remaining == STEP_W'(1))
                  state <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Default freezes the counter by reloading its own value; this also
   // holds while rstn is low, where the handshakes are forced inactive.
   always_comb begin
      cmd_ready = 1'b0;
      load_en   = 1'b1;
      load      = count_i;
      down      = 1'b0;
      busy      = 1'b0;
      rsp_valid = 1'b0;
      rsp_count = '0;
      rsp_wrap  = 1'b0;
      if (rstn) begin
         case (state)
            S_IDLE: cmd_ready = 1'b1;
            S_LOAD: begin
               busy = 1'b1;
               load = value_q;
            end
            S_RUN: begin
               busy    = 1'b1;
               load_en = 1'b0;
               down    = (op_q == OP_DOWN);
            end
            S_RESP: begin
               busy      = 1'b1;
               rsp_valid = 1'b1;
               rsp_count = count_i;
               rsp_wrap  = wrap_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cnt_cmd_ctrl.sv
// Bench for cnt_cmd_ctrl with a behavioural up/down counter attached.
// Expected responses come from modular arithmetic on a model count.
module tb_cnt_cmd_ctrl;

   localparam int WIDTH  = 4;
   localparam int STEP_W = 8;
   localparam int MODV   = 1 << WIDTH;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [1:0]        cmd_op = '0;
   logic [WIDTH-1:0]  cmd_value = '0;
   logic [STEP_W-1:0] cmd_steps = '0;
   logic [WIDTH-1:0]  count_i;
   logic              rollover_i;
   logic              load_en;
   logic [WIDTH-1:0]  load;
   logic              down;
   logic              busy;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [WIDTH-1:0]  rsp_count;
   logic              rsp_wrap;

   int total = 0;
   int bad   = 0;
   int n_acc = 0;
   int n_rsp = 0;
   int mdl_cnt = 0;

   always #5 clk = ~clk;

   cnt_cmd_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_value(cmd_value), .cmd_steps(cmd_steps),
      .count_i(count_i), .rollover_i(rollover_i),
      .load_en(load_en), .load(load), .down(down), .busy(busy),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_count(rsp_count), .rsp_wrap(rsp_wrap)
   );

   // Counter under control: load has priority, otherwise count up or down.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        count_i <= '0;
      else if (load_en) count_i <= load;
      else if (down)    count_i <= count_i - 1'b1;
      else              count_i <= count_i + 1'b1;
   end
   assign rollover_i = (count_i == '1);

   always @(posedge clk) begin
      if (cmd_valid && cmd_ready) n_acc++;
      if (rsp_valid && rsp_ready) n_rsp++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Issue one command and check the response against the model.
   // Called and returns on a negative clock edge.
   task automatic run_cmd(input logic [1:0] op, input int val, input int steps,
                          input int hold, input int gap);
      int exp_cnt, exp_wrap, exp_lat, d, waited, lat;
      case (op)
         2'd0: begin exp_cnt = val; exp_wrap = 0; exp_lat = 2; end
         2'd1: begin
            d = mdl_cnt + steps;
            exp_cnt = d % MODV;
            exp_wrap = (d >= MODV) ? 1 : 0;
            exp_lat = (steps == 0) ? 1 : steps + 1;
         end
         2'd2: begin
            d = mdl_cnt - steps;
            exp_cnt = ((d % MODV) + MODV) % MODV;
            exp_wrap = (steps > mdl_cnt) ? 1 : 0;
            exp_lat = (steps == 0) ? 1 : steps + 1;
         end
         default: begin exp_cnt = mdl_cnt; exp_wrap = 0; exp_lat = 1; end
      endcase

      repeat (gap) @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_value = WIDTH'(val);
      cmd_steps = STEP_W'(steps);
      waited = 0;
      while (!cmd_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      chk("cmd_ready_idle", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_value = WIDTH'($urandom);
      cmd_steps = STEP_W'($urandom);

      lat = 1;
      while (!rsp_valid && lat < 400) begin
         chk("busy_running", busy, 1);
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("rsp_count", rsp_count, exp_cnt);
      chk("rsp_wrap", rsp_wrap, exp_wrap);
      chk("cmd_ready_resp", cmd_ready, 0);

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_count", rsp_count, exp_cnt);
         chk("hold_wrap", rsp_wrap, exp_wrap);
         chk("hold_cmd_ready", cmd_ready, 0);
      end

      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_done", rsp_valid, 0);
      chk("count_after", count_i, exp_cnt);
      chk("one_acc_per_rsp", n_acc - n_rsp, 0);
      mdl_cnt = exp_cnt;
   endtask

   initial begin
      int op, st;

      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_load_en", load_en, 1);
      chk("rst_down", down, 0);
      chk("rst_load", load, count_i);
      rstn = 1'b1;
      @(negedge clk);
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_busy", busy, 0);
      mdl_cnt = 0;

      run_cmd(2'd0, 4'hA, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_frozen", count_i, 4'hA);
      end

      run_cmd(2'd0, 4'hD, 0, 0, 0);
      run_cmd(2'd1, 0, 5, 0, 0);
      chk("up5_count", mdl_cnt, 4'h2);

      run_cmd(2'd0, 4'h1, 0, 0, 1);
      run_cmd(2'd2, 0, 3, 1, 0);
      chk("down3_count", mdl_cnt, 4'hE);
      run_cmd(2'd0, 4'h1, 0, 0, 0);
      run_cmd(2'd2, 0, 1, 0, 0);
      chk("down1_count", mdl_cnt, 0);

      run_cmd(2'd0, 4'h7, 0, 0, 0);
      run_cmd(2'd3, 0, 0, 4, 0);
      run_cmd(2'd1, 0, 0, 4, 0);
      chk("read_count", mdl_cnt, 4'h7);

      // Reset in the middle of a long run.
      cmd_valid = 1'b1;
      cmd_op    = 2'd1;
      cmd_steps = 8'd200;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (49) @(negedge clk);
      chk("midrun_busy", busy, 1);
      chk("midrun_count", count_i, (mdl_cnt + 49) % MODV);
      rstn = 1'b0;
      #1;
      chk("abort_cmd_ready", cmd_ready, 0);
      chk("abort_rsp_valid", rsp_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_count", count_i, 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_cmd_ready", cmd_ready, 1);
      chk("post_rst_rsp_valid", rsp_valid, 0);
      chk("post_rst_count", count_i, 0);
      n_acc = 0;
      n_rsp = 0;
      mdl_cnt = 0;

      for (int k = 0; k < 40; k++) begin
         op = $urandom_range(0, 3);
         st = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
         run_cmd(2'(op), $urandom_range(0, MODV - 1), st,
                 $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, bench did not finish");
      $fatal(1, "watchdog");
   end

endmodule
